// File: rtl/l2_req_arbiter.sv
// l2_req_arbiter: single-outstanding-op scheduler in front of the unified L2 lookup engine.
// Snoop-first priority with starvation relief for L1, and round-robin between L1 data and instruction.
module l2_req_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int CMD_W        = 4,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              snp_req,
  input  logic [CMD_W-1:0]  snp_cmd,
  input  logic [ADDR_W-1:0] snp_addr,
  input  logic              d_req,
  input  logic [CMD_W-1:0]  d_cmd,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              snp_gnt,
  output logic              d_gnt,
  output logic              i_gnt,
  output logic              l2_valid,
  output logic [CMD_W-1:0]  l2_cmd,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [1:0]        l2_src,
  input  logic              l2_ready,
  input  logic              l2_done,
  output logic              busy,
  output logic              err_unexp,
  output logic [CNT_W-1:0]  snp_cnt,
  output logic [CNT_W-1:0]  d_cnt,
  output logic [CNT_W-1:0]  i_cnt
);

  localparam int                ST_W       = $clog2(STARVE_LIMIT + 1);
  localparam logic [ST_W-1:0]   STARVE_MAX = ST_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [1:0]        SRC_NONE   = 2'b00;
  localparam logic [1:0]        SRC_DATA   = 2'b01;
  localparam logic [1:0]        SRC_INSTR  = 2'b10;
  localparam logic [1:0]        SRC_SNOOP  = 2'b11;
  localparam logic [CMD_W-1:0]  CMD_IFETCH = CMD_W'(2);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             last_l1_data;
  logic [ST_W-1:0]  starve;
  logic             l1_pend;
  logic             any_req;
  logic             force_l1;
  logic             take_snp;
  logic             take_data;
  logic             take_instr;
  logic             err_next;
  logic             op_retire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Winner selection only matters in IDLE; the starvation counter lets a waiting L1 request
  // overtake a continuous snoop stream once it has been passed over STARVE_LIMIT times.
  always_comb begin
    state_next = state;
    take_snp   = 1'b0;
    take_data  = 1'b0;
    take_instr = 1'b0;
    err_next   = 1'b0;
    op_retire  = 1'b0;
    l1_pend    = d_req | i_req;
    any_req    = snp_req | l1_pend;
    force_l1   = l1_pend && (starve == STARVE_MAX);
    case (state)
      IDLE: begin
        err_next = l2_done;
        if (any_req) begin
          state_next = ISSUE;
          if (snp_req && !force_l1) begin
            take_snp = 1'b1;
          end else if (d_req && (!i_req || !last_l1_data)) begin
            take_data = 1'b1;
          end else begin
            take_instr = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (l2_ready) begin
          if (l2_done) begin
            state_next = IDLE;
            op_retire  = 1'b1;
          end else begin
            state_next = WAIT_DONE;
          end
        end else begin
          err_next = l2_done;
        end
      end
      WAIT_DONE: begin
        if (l2_done) begin
          state_next = IDLE;
          op_retire  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign l2_valid = (state == ISSUE);
  assign busy     = (state != IDLE);

  // Operation latch, grant pulses, fairness state and saturating statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      snp_gnt      <= 1'b0;
      d_gnt        <= 1'b0;
      i_gnt        <= 1'b0;
      err_unexp    <= 1'b0;
      l2_cmd       <= '0;
      l2_addr      <= '0;
      l2_src       <= SRC_NONE;
      last_l1_data <= 1'b0;
      starve       <= '0;
      snp_cnt      <= '0;
      d_cnt        <= '0;
      i_cnt        <= '0;
    end else begin
      snp_gnt   <= take_snp;
      d_gnt     <= take_data;
      i_gnt     <= take_instr;
      err_unexp <= err_next;
      if (take_snp) begin
        l2_cmd  <= snp_cmd;
        l2_addr <= snp_addr;
        l2_src  <= SRC_SNOOP;
        if (l1_pend && (starve != STARVE_MAX)) begin
          starve <= starve + 1'b1;
        end
      end else if (take_data) begin
        l2_cmd       <= d_cmd;
        l2_addr      <= d_addr;
        l2_src       <= SRC_DATA;
        last_l1_data <= 1'b1;
        starve       <= '0;
      end else if (take_instr) begin
        l2_cmd       <= CMD_IFETCH;
        l2_addr      <= i_addr;
        l2_src       <= SRC_INSTR;
        last_l1_data <= 1'b0;
        starve       <= '0;
      end else if (op_retire) begin
        l2_src <= SRC_NONE;
      end
      if (take_snp && (snp_cnt != CNT_MAX)) begin
        snp_cnt <= snp_cnt + 1'b1;
      end
      if (take_data && (d_cnt != CNT_MAX)) begin
        d_cnt <= d_cnt + 1'b1;
      end
      if (take_instr && (i_cnt != CNT_MAX)) begin
        i_cnt <= i_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_l2_req_arbiter.sv
// tb_l2_req_arbiter: directed table, multi-cycle corner sequences and a randomized run
// against a transaction-level reference model; a CNT_W=2 twin shares all inputs.
module tb_l2_req_arbiter;

  localparam int ADDR_W = 32;
  localparam int CMD_W  = 4;
  localparam int LIM    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              snp_req = 1'b0, d_req = 1'b0, i_req = 1'b0;
  logic [CMD_W-1:0]  snp_cmd = '0, d_cmd = '0;
  logic [ADDR_W-1:0] snp_addr = '0, d_addr = '0, i_addr = '0;
  logic              l2_ready = 1'b0, l2_done = 1'b0;

  logic              snp_gnt, d_gnt, i_gnt, l2_valid, busy, err_unexp;
  logic [CMD_W-1:0]  l2_cmd;
  logic [ADDR_W-1:0] l2_addr;
  logic [1:0]        l2_src;
  logic [15:0]       snp_cnt, d_cnt, i_cnt;

  logic              sm_snp_gnt, sm_d_gnt, sm_i_gnt, sm_l2_valid, sm_busy, sm_err_unexp;
  logic [CMD_W-1:0]  sm_l2_cmd;
  logic [ADDR_W-1:0] sm_l2_addr;
  logic [1:0]        sm_l2_src;
  logic [1:0]        sm_snp_cnt, sm_d_cnt, sm_i_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  l2_req_arbiter #(.ADDR_W(ADDR_W), .CMD_W(CMD_W), .STARVE_LIMIT(LIM), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .snp_req(snp_req), .snp_cmd(snp_cmd), .snp_addr(snp_addr),
    .d_req(d_req), .d_cmd(d_cmd), .d_addr(d_addr),
    .i_req(i_req), .i_addr(i_addr),
    .snp_gnt(snp_gnt), .d_gnt(d_gnt), .i_gnt(i_gnt),
    .l2_valid(l2_valid), .l2_cmd(l2_cmd), .l2_addr(l2_addr), .l2_src(l2_src),
    .l2_ready(l2_ready), .l2_done(l2_done),
    .busy(busy), .err_unexp(err_unexp),
    .snp_cnt(snp_cnt), .d_cnt(d_cnt), .i_cnt(i_cnt)
  );

  l2_req_arbiter #(.ADDR_W(ADDR_W), .CMD_W(CMD_W), .STARVE_LIMIT(LIM), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst),
    .snp_req(snp_req), .snp_cmd(snp_cmd), .snp_addr(snp_addr),
    .d_req(d_req), .d_cmd(d_cmd), .d_addr(d_addr),
    .i_req(i_req), .i_addr(i_addr),
    .snp_gnt(sm_snp_gnt), .d_gnt(sm_d_gnt), .i_gnt(sm_i_gnt),
    .l2_valid(sm_l2_valid), .l2_cmd(sm_l2_cmd), .l2_addr(sm_l2_addr), .l2_src(sm_l2_src),
    .l2_ready(l2_ready), .l2_done(l2_done),
    .busy(sm_busy), .err_unexp(sm_err_unexp),
    .snp_cnt(sm_snp_cnt), .d_cnt(sm_d_cnt), .i_cnt(sm_i_cnt)
  );

  // Reference model: op phase 0=none, 1=presented, 2=accepted; counts are unbounded integers.
  bit          model_on = 1'b0;
  int          m_phase, m_starve, m_sc, m_dc, m_ic;
  bit          m_last_d, m_gs, m_gd, m_gi, m_err;
  logic [1:0]  m_src;
  logic [3:0]  m_cmd;
  logic [31:0] m_addr;

  function automatic int sat3(input int c);
    return (c > 3) ? 3 : c;
  endfunction

  task automatic model_step();
    bit l1;
    if (rst) begin
      m_phase = 0; m_starve = 0; m_sc = 0; m_dc = 0; m_ic = 0;
      m_last_d = 0; m_gs = 0; m_gd = 0; m_gi = 0; m_err = 0;
      m_src = 2'b00; m_cmd = '0; m_addr = '0;
      return;
    end
    m_gs = 0; m_gd = 0; m_gi = 0; m_err = 0;
    if (m_phase == 0) begin
      if (l2_done) m_err = 1;
      if (snp_req || d_req || i_req) begin
        l1 = d_req || i_req;
        if (snp_req && !(l1 && m_starve >= LIM)) begin
          m_gs = 1; m_sc++;
          if (l1 && m_starve < LIM) m_starve++;
          m_src = 2'b11; m_cmd = snp_cmd; m_addr = snp_addr;
        end else begin
          if (d_req && !(i_req && m_last_d)) begin
            m_gd = 1; m_dc++; m_last_d = 1;
            m_src = 2'b01; m_cmd = d_cmd; m_addr = d_addr;
          end else begin
            m_gi = 1; m_ic++; m_last_d = 0;
            m_src = 2'b10; m_cmd = 4'd2; m_addr = i_addr;
          end
          m_starve = 0;
        end
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (l2_ready) begin
        if (l2_done) begin m_phase = 0; m_src = 2'b00; end
        else m_phase = 2;
      end else if (l2_done) begin
        m_err = 1;
      end
    end else if (l2_done) begin
      m_phase = 0; m_src = 2'b00;
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic s, input logic d, input logic i,
                                input logic rdy, input logic dn);
    rst = r; snp_req = s; d_req = d; i_req = i; l2_ready = rdy; l2_done = dn;
    @(posedge clk);
    if (model_on) model_step();
    #1;
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_v, input logic [1:0] e_src,
                           input logic [2:0] e_gnt, input logic e_err, input logic e_busy,
                           input int e_sc, input int e_dc, input int e_ic,
                           input logic chk_bus, input logic [3:0] e_cmd, input logic [31:0] e_addr);
    check_output({tag, ".valid"}, l2_valid, e_v);
    check_output({tag, ".src"}, l2_src, e_src);
    check_output({tag, ".gnt"}, {snp_gnt, d_gnt, i_gnt}, e_gnt);
    check_output({tag, ".err"}, err_unexp, e_err);
    check_output({tag, ".busy"}, busy, e_busy);
    check_output({tag, ".snp_cnt"}, snp_cnt, 64'(e_sc));
    check_output({tag, ".d_cnt"}, d_cnt, 64'(e_dc));
    check_output({tag, ".i_cnt"}, i_cnt, 64'(e_ic));
    check_output({tag, ".sm_snp_cnt"}, sm_snp_cnt, 64'(sat3(e_sc)));
    check_output({tag, ".sm_d_cnt"}, sm_d_cnt, 64'(sat3(e_dc)));
    check_output({tag, ".sm_i_cnt"}, sm_i_cnt, 64'(sat3(e_ic)));
    if (chk_bus) begin
      check_output({tag, ".cmd"}, l2_cmd, e_cmd);
      check_output({tag, ".addr"}, l2_addr, e_addr);
    end
  endtask

  typedef struct {
    logic r, s, d, i, rdy, dn;
    logic v;
    logic [1:0] src;
    logic [2:0] gnt;
    logic err, bsy;
    int sc, dc, ic;
    logic [3:0] cmd;
    logic [31:0] addr;
  } vec_t;

  function automatic vec_t mk(input logic r, s, d, i, rdy, dn, v, input logic [1:0] src,
                              input logic [2:0] gnt, input logic err, bsy,
                              input int sc, dc, ic, input logic [3:0] cmd, input logic [31:0] addr);
    vec_t t;
    t.r = r; t.s = s; t.d = d; t.i = i; t.rdy = rdy; t.dn = dn;
    t.v = v; t.src = src; t.gnt = gnt; t.err = err; t.bsy = bsy;
    t.sc = sc; t.dc = dc; t.ic = ic; t.cmd = cmd; t.addr = addr;
    return t;
  endfunction

  vec_t tbl [17];

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    string order;
    int    cyc;
    bit    d_pend, s_pend, i_pend, rr;

    // Directed table: single data op, snoop/data/instr fan-in, done-in-IDLE, ready-in-IDLE.
    //              r s d i rdy dn | v  src    gnt    err bsy sc dc ic cmd   addr
    tbl[0]  = mk(1,0,0,0,0,0, 0,2'b00,3'b000,0,0, 0,0,0, 4'd0,32'h0);
    tbl[1]  = mk(0,0,1,0,1,0, 1,2'b01,3'b010,0,1, 0,1,0, 4'd1,32'h0000_1040);
    tbl[2]  = mk(0,0,0,0,1,0, 0,2'b01,3'b000,0,1, 0,1,0, 4'd0,32'h0);
    tbl[3]  = mk(0,0,0,0,0,0, 0,2'b01,3'b000,0,1, 0,1,0, 4'd0,32'h0);
    tbl[4]  = mk(0,0,0,0,0,1, 0,2'b00,3'b000,0,0, 0,1,0, 4'd0,32'h0);
    tbl[5]  = mk(1,0,0,0,0,0, 0,2'b00,3'b000,0,0, 0,0,0, 4'd0,32'h0);
    tbl[6]  = mk(0,1,1,1,0,0, 1,2'b11,3'b100,0,1, 1,0,0, 4'd7,32'h0000_3000);
    tbl[7]  = mk(0,0,1,1,1,1, 0,2'b00,3'b000,0,0, 1,0,0, 4'd0,32'h0);
    tbl[8]  = mk(0,0,1,1,0,0, 1,2'b01,3'b010,0,1, 1,1,0, 4'd1,32'h0000_1040);
    tbl[9]  = mk(0,0,0,1,1,0, 0,2'b01,3'b000,0,1, 1,1,0, 4'd0,32'h0);
    tbl[10] = mk(0,0,0,1,0,1, 0,2'b00,3'b000,0,0, 1,1,0, 4'd0,32'h0);
    tbl[11] = mk(0,0,0,1,0,0, 1,2'b10,3'b001,0,1, 1,1,1, 4'd2,32'h0000_2080);
    tbl[12] = mk(0,0,0,0,1,0, 0,2'b10,3'b000,0,1, 1,1,1, 4'd0,32'h0);
    tbl[13] = mk(0,0,0,0,0,1, 0,2'b00,3'b000,0,0, 1,1,1, 4'd0,32'h0);
    tbl[14] = mk(0,0,0,0,0,1, 0,2'b00,3'b000,1,0, 1,1,1, 4'd0,32'h0);
    tbl[15] = mk(0,0,0,0,0,0, 0,2'b00,3'b000,0,0, 1,1,1, 4'd0,32'h0);
    tbl[16] = mk(0,0,0,0,1,0, 0,2'b00,3'b000,0,0, 1,1,1, 4'd0,32'h0);

    snp_cmd = 4'd7; snp_addr = 32'h0000_3000;
    d_cmd = 4'd1; d_addr = 32'h0000_1040; i_addr = 32'h0000_2080;

    for (int k = 0; k < 17; k++) begin
      apply_stimulus(tbl[k].r, tbl[k].s, tbl[k].d, tbl[k].i, tbl[k].rdy, tbl[k].dn);
      check_all($sformatf("tbl%0d", k), tbl[k].v, tbl[k].src, tbl[k].gnt, tbl[k].err, tbl[k].bsy,
                tbl[k].sc, tbl[k].dc, tbl[k].ic, tbl[k].v | tbl[k].r, tbl[k].cmd, tbl[k].addr);
    end

    // Starvation: a continuous snoop stream must yield to data after LIM snoop grants.
    apply_stimulus(1, 0, 0, 0, 0, 0);
    d_pend = 1; order = ""; cyc = 0;
    while (order.len() < 6 && cyc < 80) begin
      apply_stimulus(0, 1, d_pend, 0, 1, busy & ~l2_valid);
      if (snp_gnt) order = {order, "S"};
      if (d_gnt) begin order = {order, "D"}; d_pend = 0; end
      cyc++;
    end
    n_checks++;
    if (order != "SSSSDS") begin
      n_errors++;
      $display("[TB] FAIL starve_order: got %s, expected SSSSDS", order);
    end

    // L2 back-pressure: op held stable, single grant, done-before-ready flagged.
    apply_stimulus(1, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 1, 0, 0, 0);
    check_all("stall_gnt", 1, 2'b01, 3'b010, 0, 1, 0, 1, 0, 1, 4'd1, 32'h0000_1040);
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(0, 0, 0, 0, 0, 0);
      check_all($sformatf("stall%0d", k), 1, 2'b01, 3'b000, 0, 1, 0, 1, 0, 1, 4'd1, 32'h0000_1040);
    end
    apply_stimulus(0, 0, 0, 0, 0, 1);
    check_all("stall_done_early", 1, 2'b01, 3'b000, 1, 1, 0, 1, 0, 1, 4'd1, 32'h0000_1040);
    apply_stimulus(0, 0, 0, 0, 1, 0);
    check_all("stall_accept", 0, 2'b01, 3'b000, 0, 1, 0, 1, 0, 0, 4'd0, 32'h0);
    apply_stimulus(0, 0, 0, 0, 0, 1);
    check_all("stall_retire", 0, 2'b00, 3'b000, 0, 0, 0, 1, 0, 0, 4'd0, 32'h0);

    // Saturation on the 2-bit twin, then reset in the middle of an accepted op.
    apply_stimulus(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(0, 0, 1, 0, 0, 0);
      apply_stimulus(0, 0, 0, 0, 1, 0);
      apply_stimulus(0, 0, 0, 0, 0, 1);
    end
    check_all("sat", 0, 2'b00, 3'b000, 0, 0, 0, 5, 0, 0, 4'd0, 32'h0);
    apply_stimulus(0, 0, 1, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 1, 0);
    check_all("pre_rst_wait", 0, 2'b01, 3'b000, 0, 1, 0, 6, 0, 0, 4'd0, 32'h0);
    apply_stimulus(1, 0, 0, 0, 0, 0);
    check_all("rst_in_wait", 0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 1, 4'd0, 32'h0);

    // Randomized traffic against the reference model, including random L2 handshakes and resets.
    model_on = 1;
    apply_stimulus(1, 0, 0, 0, 0, 0);
    s_pend = 0; d_pend = 0; i_pend = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!s_pend && $urandom_range(0, 3) == 0) begin
        s_pend = 1; snp_addr = $urandom; snp_cmd = 4'($urandom_range(0, 15));
      end
      if (!d_pend && $urandom_range(0, 3) == 0) begin
        d_pend = 1; d_addr = $urandom; d_cmd = 4'($urandom_range(0, 15));
      end
      if (!i_pend && $urandom_range(0, 3) == 0) begin
        i_pend = 1; i_addr = $urandom;
      end
      rr = ($urandom_range(0, 399) == 0);
      apply_stimulus(rr, s_pend, d_pend, i_pend, $urandom_range(0, 2) != 0,
                     $urandom_range(0, 3) == 0);
      if (m_gs) s_pend = 0;
      if (m_gd) d_pend = 0;
      if (m_gi) i_pend = 0;
      check_all($sformatf("rnd%0d", c), m_phase == 1, m_src, {m_gs, m_gd, m_gi}, m_err,
                m_phase != 0, m_sc, m_dc, m_ic, m_phase == 1, m_cmd, m_addr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
